// File: rtl/reg_file_param.sv
// Parametrised 2-read/1-write register file with write-to-read bypass and a hardware clear sequencer.
// Optional hardwired zero register at entry 0 when ZERO_REG_EN is defined.
module reg_file_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic [DATA_W-1:0] rd1_data,
    input  logic              clr_req,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_fire;

    // A write lands only in IDLE with no clear request competing for the same cycle.
    always_comb begin
        wr_fire = (state == IDLE) && wr_en && !clr_req;
`ifdef ZERO_REG_EN
        if (wr_addr == '0) begin
            wr_fire = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

    // Storage has no reset; the clear sequencer is the only thing that zeroes it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (wr_fire) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd0_data = mem[rd0_addr];
        rd1_data = mem[rd1_addr];
        if (wr_fire && (rd0_addr == wr_addr)) begin
            rd0_data = wr_data;
        end
        if (wr_fire && (rd1_addr == wr_addr)) begin
            rd1_data = wr_data;
        end
`ifdef ZERO_REG_EN
        if (rd0_addr == '0) begin
            rd0_data = '0;
        end
        if (rd1_addr == '0) begin
            rd1_data = '0;
        end
`endif
        if (busy) begin
            rd0_data = '0;
            rd1_data = '0;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Randomized bench for reg_file_param against an array-based reference model.
// Define ZERO_REG_EN for both files to exercise the hardwired zero register.
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [2:0]  rd0_addr = '0;
    logic [2:0]  rd1_addr = '0;
    logic [15:0] rd0_data;
    logic [15:0] rd1_data;
    logic        clr_req = 1'b0;
    logic        busy;

    int total = 0;
    int bad = 0;

    logic [15:0] model_mem [8];
    int          clear_left = 0;

    reg_file_param #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd0_addr (rd0_addr),
        .rd1_addr (rd1_addr),
        .rd0_data (rd0_data),
        .rd1_data (rd1_data),
        .clr_req  (clr_req),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic zero_reg_on();
`ifdef ZERO_REG_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // What a read port should show right now, given the current inputs.
    function automatic logic [15:0] model_read(input logic [2:0] a);
        if (clear_left > 0) return 16'h0000;
        if (zero_reg_on() && a == 3'd0) return 16'h0000;
        if (wr_en && !clr_req && a == wr_addr) return wr_data;
        return model_mem[a];
    endfunction

    task automatic model_reset();
        clear_left = 8;
        for (int i = 0; i < 8; i++) model_mem[i] = 16'h0000;
    endtask

    task automatic set_in(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                          input logic [2:0] r0, input logic [2:0] r1, input logic cr);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd0_addr = r0; rd1_addr = r1; clr_req = cr;
        #1;
    endtask

    // Advance one clock; model is updated from the inputs held across the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (clear_left > 0) begin
                clear_left--;
            end else if (clr_req) begin
                model_reset();
            end else if (wr_en && !(zero_reg_on() && wr_addr == 3'd0)) begin
                model_mem[wr_addr] = wr_data;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || rd0_data !== 16'h0 || rd1_data !== 16'h0) begin
            bad++;
            $display("FAIL reset_values: busy=%b rd0=%h rd1=%h required busy=1 rd0=0 rd1=0", busy, rd0_data, rd1_data);
        end
        rst = 1'b0;
        model_reset();
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL reset_busy_len: got %0d cycles required 8", n);
        end
        for (int i = 0; i < 8; i++) begin
            set_in(0, 0, 0, 3'(i), 3'(7 - i), 0);
            total++;
            if (rd0_data !== 16'h0 || rd1_data !== 16'h0) begin
                bad++;
                $display("FAIL reset_entries[%0d]: rd0=%h rd1=%h required 0000", i, rd0_data, rd1_data);
            end
        end
    endtask

    task automatic test_write_readback();
        set_in(1, 3, 16'h1234, 0, 0, 0);
        tick();
        set_in(1, 7, 16'hBEEF, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 3, 7, 0);
        total++;
        if (rd0_data !== 16'h1234 || rd1_data !== 16'hBEEF) begin
            bad++;
            $display("FAIL write_readback: rd0=%h rd1=%h required 1234 beef", rd0_data, rd1_data);
        end
    endtask

    task automatic test_bypass();
        set_in(1, 5, 16'h0001, 0, 0, 0);
        tick();
        set_in(1, 5, 16'hA5A5, 5, 5, 0);
        total++;
        if (rd0_data !== 16'hA5A5 || rd1_data !== 16'hA5A5) begin
            bad++;
            $display("FAIL bypass_same_cycle: rd0=%h rd1=%h required a5a5", rd0_data, rd1_data);
        end
        tick();
        set_in(0, 0, 0, 5, 3, 0);
        total++;
        if (rd0_data !== 16'hA5A5 || rd1_data !== 16'h1234) begin
            bad++;
            $display("FAIL bypass_after: rd0=%h rd1=%h required a5a5 1234", rd0_data, rd1_data);
        end
    endtask

    task automatic test_clear_vs_write();
        int n;
        set_in(1, 2, 16'hFFFF, 2, 5, 1);
        total++;
        if (rd0_data !== 16'h0000 || rd1_data !== 16'hA5A5) begin
            bad++;
            $display("FAIL clear_wins_no_bypass: rd0=%h rd1=%h required 0000 a5a5", rd0_data, rd1_data);
        end
        tick();
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            set_in(1, 2, 16'hFFFF, 2, 5, (n == 3));
            total++;
            if (rd0_data !== 16'h0 || rd1_data !== 16'h0) begin
                bad++;
                $display("FAIL clear_reads_zero: rd0=%h rd1=%h required 0000", rd0_data, rd1_data);
            end
            n++;
            tick();
        end
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL clear_busy_len: got %0d cycles required 8", n);
        end
        set_in(0, 0, 0, 2, 5, 0);
        total++;
        if (rd0_data !== 16'h0000 || rd1_data !== 16'h0000) begin
            bad++;
            $display("FAIL clear_result: rd0=%h rd1=%h required 0000", rd0_data, rd1_data);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        set_in(1, 4, 16'h4444, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 4, 4, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 4, 4, 0);
            tick();
        end
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_clear_rst_busy: busy=%b required 1", busy);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL mid_clear_busy_len: got %0d cycles required 8", n);
        end
        set_in(0, 0, 0, 4, 7, 0);
        total++;
        if (rd0_data !== 16'h0 || rd1_data !== 16'h0) begin
            bad++;
            $display("FAIL mid_clear_result: rd0=%h rd1=%h required 0000", rd0_data, rd1_data);
        end
    endtask

    task automatic test_zero_reg();
        logic [15:0] exp;
        exp = zero_reg_on() ? 16'h0000 : 16'h7777;
        set_in(1, 0, 16'h7777, 0, 1, 0);
        total++;
        if (rd0_data !== exp) begin
            bad++;
            $display("FAIL zero_reg_bypass: rd0=%h required %h", rd0_data, exp);
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        total++;
        if (rd0_data !== exp || rd1_data !== exp) begin
            bad++;
            $display("FAIL zero_reg_mem: rd0=%h rd1=%h required %h", rd0_data, rd1_data, exp);
        end
    endtask

    task automatic test_random();
        logic [15:0] e0;
        logic [15:0] e1;
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom()),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), ($urandom_range(0, 24) == 0));
            e0 = model_read(rd0_addr);
            e1 = model_read(rd1_addr);
            total++;
            if (rd0_data !== e0 || rd1_data !== e1 || busy !== (clear_left > 0)) begin
                bad++;
                $display("FAIL random[%0d]: rd0=%h rd1=%h busy=%b required %h %h %b",
                         i, rd0_data, rd1_data, busy, e0, e1, (clear_left > 0));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_bypass();
        test_clear_vs_write();
        test_reset_mid_clear();
        test_zero_reg();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
